// File: rtl/multi_alarm_clock.sv
// 24-hour clock kept in binary with BCD display outputs, NUM_ALARMS independent
// alarm channels with per-channel snooze, and range-checked time/alarm loads.
module multi_alarm_clock #(
    parameter int unsigned CLK_PER_SEC = 10,
    parameter int unsigned NUM_ALARMS  = 4,
    parameter int unsigned SNOOZE_MIN  = 5,
    parameter int unsigned SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            hou1,
    input  logic [3:0]            hou0,
    input  logic [3:0]            min1,
    input  logic [3:0]            min0,
    input  logic                  loatim,
    input  logic                  loaala,
    input  logic [SEL_W-1:0]      alasel,
    input  logic                  alaon,
    input  logic                  stoala,
    input  logic                  snooze,
    output logic                  alarm,
    output logic [NUM_ALARMS-1:0] alavec,
    output logic [1:0]            houout1,
    output logic [3:0]            houout0,
    output logic [3:0]            minout1,
    output logic [3:0]            minout0,
    output logic [3:0]            secout1,
    output logic [3:0]            secout0,
    output logic                  tick,
    output logic                  lderr
);

    localparam int unsigned    PW         = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0]  PrescMax   = PW'(CLK_PER_SEC - 1);
    localparam logic [SEL_W:0] NumAlarmsW = (SEL_W + 1)'(NUM_ALARMS);
    localparam logic [6:0]     SnoozeMin  = 7'(SNOOZE_MIN);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          lderr_q, lderr_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;

    logic [NUM_ALARMS-1:0] ring_q, ring_d, en_q, en_d, pend_q, pend_d;
    logic [4:0] ala_hour_q [NUM_ALARMS];
    logic [4:0] ala_hour_d [NUM_ALARMS];
    logic [5:0] ala_min_q  [NUM_ALARMS];
    logic [5:0] ala_min_d  [NUM_ALARMS];
    logic [4:0] snz_hour_q [NUM_ALARMS];
    logic [4:0] snz_hour_d [NUM_ALARMS];
    logic [5:0] snz_min_q  [NUM_ALARMS];
    logic [5:0] snz_min_d  [NUM_ALARMS];

    logic [5:0] ld_hour, ld_min;
    logic       fields_ok, sel_ok, time_ld, ala_ld, min_evt;
    logic [4:0] nxt_hour, snz_hour_new;
    logic [5:0] nxt_min, snz_min_new;
    logic [6:0] snz_sum;
    logic [NUM_ALARMS-1:0] wr_ch, ala_hit, snz_hit;

    // Load decode; ld_hour is 6 bits so out-of-range digit pairs are caught.
    always_comb begin
        ld_hour   = 6'(hou1) * 6'd10 + 6'(hou0);
        ld_min    = 6'(min1) * 6'd10 + 6'(min0);
        fields_ok = (hou0 <= 4'd9) && (min0 <= 4'd9) && (min1 <= 4'd5) && (ld_hour <= 6'd23);
        sel_ok    = {1'b0, alasel} < NumAlarmsW;
        time_ld   = loatim && fields_ok;
        ala_ld    = loaala && fields_ok && sel_ok;
    end

    always_comb begin
        nxt_min  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        nxt_hour = hour_q;
        if (min_q == 6'd59) begin
            nxt_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
        min_evt = tick_q && !time_ld && (sec_q == 6'd59);

        snz_sum      = 7'(min_q) + SnoozeMin;
        snz_min_new  = 6'(snz_sum);
        snz_hour_new = hour_q;
        if (snz_sum >= 7'd60) begin
            snz_min_new  = 6'(snz_sum - 7'd60);
            snz_hour_new = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end
    end

    always_comb begin
        presc_d = (presc_q == PrescMax) ? '0 : presc_q + 1'b1;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        if (time_ld) begin
            presc_d = '0;
            hour_d  = 5'(ld_hour);
            min_d   = ld_min;
            sec_d   = '0;
        end else if (tick_q) begin
            if (sec_q == 6'd59) begin
                sec_d  = '0;
                min_d  = nxt_min;
                hour_d = nxt_hour;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        tick_d  = (presc_d == PrescMax);
        lderr_d = (loatim && !fields_ok) || (loaala && !(fields_ok && sel_ok));
    end

    // Matches compare against the stored (pre-load) alarm and snooze times.
    always_comb begin
        wr_ch   = '0;
        ala_hit = '0;
        snz_hit = '0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            wr_ch[i]   = ala_ld && (alasel == SEL_W'(i));
            ala_hit[i] = min_evt && en_q[i] && (nxt_hour == ala_hour_q[i]) &&
                         (nxt_min == ala_min_q[i]);
            snz_hit[i] = min_evt && pend_q[i] && (nxt_hour == snz_hour_q[i]) &&
                         (nxt_min == snz_min_q[i]);
        end
    end

    always_comb begin
        ring_d     = ring_q;
        en_d       = en_q;
        pend_d     = pend_q;
        ala_hour_d = ala_hour_q;
        ala_min_d  = ala_min_q;
        snz_hour_d = snz_hour_q;
        snz_min_d  = snz_min_q;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            if ((wr_ch[i] && !alaon) || stoala) begin
                ring_d[i] = 1'b0;
                pend_d[i] = 1'b0;
            end else if (snooze && ring_q[i]) begin
                ring_d[i]     = 1'b0;
                pend_d[i]     = 1'b1;
                snz_hour_d[i] = snz_hour_new;
                snz_min_d[i]  = snz_min_new;
            end else begin
                if (ala_hit[i] || snz_hit[i]) ring_d[i] = 1'b1;
                if (snz_hit[i]) pend_d[i] = 1'b0;
            end
            if (wr_ch[i]) begin
                ala_hour_d[i] = 5'(ld_hour);
                ala_min_d[i]  = ld_min;
                en_d[i]       = alaon;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            lderr_q <= 1'b0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            ring_q  <= '0;
            en_q    <= '0;
            pend_q  <= '0;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                ala_hour_q[i] <= '0;
                ala_min_q[i]  <= '0;
                snz_hour_q[i] <= '0;
                snz_min_q[i]  <= '0;
            end
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            lderr_q    <= lderr_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            ring_q     <= ring_d;
            en_q       <= en_d;
            pend_q     <= pend_d;
            ala_hour_q <= ala_hour_d;
            ala_min_q  <= ala_min_d;
            snz_hour_q <= snz_hour_d;
            snz_min_q  <= snz_min_d;
        end
    end

    assign houout1 = 2'(hour_q / 5'd10);
    assign houout0 = 4'(hour_q % 5'd10);
    assign minout1 = 4'(min_q / 6'd10);
    assign minout0 = 4'(min_q % 6'd10);
    assign secout1 = 4'(sec_q / 6'd10);
    assign secout0 = 4'(sec_q % 6'd10);
    assign tick    = tick_q;
    assign lderr   = lderr_q;
    assign alavec  = ring_q;
    assign alarm   = |ring_q;

endmodule
